func_root: RTL and testbench

- Parametrised, iterative integer-root unit. Computes floor(sqrt(x)) or floor(cbrt(x)) of an unsigned DATA_W-bit operand.
- Runtime mode select and a start/busy handshake. Adds a one-cycle done pulse.
- Multi-cycle arithmetic block in the func family. Driven by a controller or testbench that pulses start and polls busy.

---
 rtl/func_root.sv | 177 +++++++++++++++++
 tb/tb_func_root.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/func_root.sv
// Iterative integer root unit: floor(sqrt(x)) or floor(cbrt(x)), one root digit per cycle.
// Define FUNC_ROOT_REM_EN to add the rem_bo remainder output.
module func_root #(
    parameter int DATA_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_W-1:0]       a_bi,
    input  logic                    mode_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
`ifdef FUNC_ROOT_REM_EN
    output logic [DATA_W-1:0]       rem_bo,
`endif
    output logic [(DATA_W+1)/2-1:0] y_bo
);

    localparam int OUT_W    = (DATA_W + 1) / 2;
    localparam int SQ_STEPS = (DATA_W + 1) / 2;
    localparam int CB_STEPS = (DATA_W + 2) / 3;
    localparam int SQ_XW    = 2 * SQ_STEPS;
    localparam int CB_XW    = 3 * CB_STEPS;
    // Operand shifter must hold either zero-extended layout; working width leaves headroom for shifts.
    localparam int XW       = (SQ_XW > CB_XW) ? SQ_XW : CB_XW;
    localparam int W        = XW + 4;
    localparam int CNT_W    = $clog2(SQ_STEPS + 1);

    localparam logic [W-1:0]     ONE_W   = W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]      x_q, x_d;
    logic [W-1:0]       r_q, r_d;
    logic [OUT_W-1:0]   root_q, root_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef FUNC_ROOT_REM_EN
    logic [DATA_W-1:0]  rem_q, rem_d;
`endif

    logic [1:0]         sq_pair_s;
    logic [2:0]         cb_trip_s;
    logic [W-1:0]       root_ext_s;
    logic [W-1:0]       sq_r_s, sq_t_s;
    logic               sq_ge_s;
    logic [W-1:0]       cb_r_s, cb_y2_s, cb_prod_s, cb_t_s;
    logic               cb_ge_s;

    // One restoring digit step for each mode, evaluated from the current working registers.
    always_comb begin
        sq_pair_s  = x_q[XW-1 -: 2];
        cb_trip_s  = x_q[XW-1 -: 3];
        root_ext_s = W'(root_q);

        sq_r_s     = (r_q << 2) | W'(sq_pair_s);
        sq_t_s     = (root_ext_s << 2) | ONE_W;
        sq_ge_s    = (sq_r_s >= sq_t_s);

        cb_r_s     = (r_q << 3) | W'(cb_trip_s);
        cb_y2_s    = root_ext_s << 1;
        cb_prod_s  = cb_y2_s * (cb_y2_s + ONE_W);
        cb_t_s     = (cb_prod_s << 1) + cb_prod_s + ONE_W;
        cb_ge_s    = (cb_r_s >= cb_t_s);
    end

    // Controller next-state and register updates.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        r_d     = r_q;
        root_d  = root_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FUNC_ROOT_REM_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    cnt_d   = mode_i ? CNT_W'(CB_STEPS) : CNT_W'(SQ_STEPS);
                    x_d     = mode_i ? (XW'(a_bi) << (XW - CB_XW))
                                     : (XW'(a_bi) << (XW - SQ_XW));
                    r_d     = {W{1'b0}};
                    root_d  = {OUT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_CALC: begin
                if (mode_q) begin
                    x_d    = x_q << 3;
                    r_d    = cb_ge_s ? (cb_r_s - cb_t_s) : cb_r_s;
                    root_d = OUT_W'({root_q, cb_ge_s});
                end else begin
                    x_d    = x_q << 2;
                    r_d    = sq_ge_s ? (sq_r_s - sq_t_s) : sq_r_s;
                    root_d = OUT_W'({root_q, sq_ge_s});
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                // Result and pulse become visible together, in the first IDLE cycle.
                y_d     = root_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
`ifdef FUNC_ROOT_REM_EN
                rem_d   = r_q[DATA_W-1:0];
`endif
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            x_q     <= {XW{1'b0}};
            r_q     <= {W{1'b0}};
            root_q  <= {OUT_W{1'b0}};
            y_q     <= {OUT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FUNC_ROOT_REM_EN
            rem_q   <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            r_q     <= r_d;
            root_q  <= root_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FUNC_ROOT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_bo   = y_q;
`ifdef FUNC_ROOT_REM_EN
    assign rem_bo = rem_q;
`endif

endmodule

// File: tb/tb_func_root.sv
// Directed scoreboard bench for func_root with an 8-bit and a 32-bit instance.
module tb_func_root;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a8;
    logic        mode8, start8, busy8, done8;
    logic [3:0]  y8;
    logic [31:0] a32;
    logic        mode32, start32, busy32, done32;
    logic [15:0] y32;
`ifdef FUNC_ROOT_REM_EN
    logic [7:0]  rem8;
    logic [31:0] rem32;
`endif

    always #5 clk = ~clk;

    func_root #(.DATA_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .a_bi(a8), .mode_i(mode8), .start_i(start8),
        .busy_o(busy8), .done_o(done8),
`ifdef FUNC_ROOT_REM_EN
        .rem_bo(rem8),
`endif
        .y_bo(y8)
    );

    func_root #(.DATA_W(32)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .a_bi(a32), .mode_i(mode32), .start_i(start32),
        .busy_o(busy32), .done_o(done32),
`ifdef FUNC_ROOT_REM_EN
        .rem_bo(rem32),
`endif
        .y_bo(y32)
    );

    typedef struct {
        logic [31:0] y;
        logic [31:0] rem;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   done_exp = 0;
    logic [31:0] last_y8 = 32'd0;
    logic [31:0] last_y32 = 32'd0;

    // Count every done pulse from either instance.
    always @(posedge clk) begin
        if (done8 === 1'b1) done_cnt <= done_cnt + 1;
        if (done32 === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Push expectation, pulse start for one edge; returns #1 after the start edge.
    task automatic launch(input bit wide, input logic [31:0] a, input logic m,
                          input logic [31:0] ey, input logic [31:0] erem, input int elat);
        exp_t e;
        e.y = ey; e.rem = erem; e.lat = elat;
        exp_q.push_back(e);
        if (wide) begin a32 = a; mode32 = m; start32 = 1'b1; end
        else begin a8 = a[7:0]; mode8 = m; start8 = 1'b1; end
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        if (wide) chk("y32_hold", 32'(y32), last_y32);
        else chk("y8_hold", 32'(y8), last_y8);
    endtask

    // Wait for busy to drop (bounded) and compare against the oldest expectation.
    task automatic complete(input bit wide, input string tag, input int lat0);
        exp_t e;
        int lat;
        lat = lat0;
        while (((wide ? busy32 : busy8) === 1'b1) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        done_exp++;
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        if (wide) begin
            chk({tag, "_done"}, 32'(done32), 32'd1);
            chk({tag, "_y"}, 32'(y32), e.y);
`ifdef FUNC_ROOT_REM_EN
            chk({tag, "_rem"}, rem32, e.rem);
`endif
            last_y32 = e.y;
        end else begin
            chk({tag, "_done"}, 32'(done8), 32'd1);
            chk({tag, "_y"}, 32'(y8), e.y);
`ifdef FUNC_ROOT_REM_EN
            chk({tag, "_rem"}, 32'(rem8), e.rem);
`endif
            last_y8 = e.y;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a8 = 8'd0; mode8 = 1'b0; start8 = 1'b1;
        a32 = 32'd0; mode32 = 1'b0; start32 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_y8", 32'(y8), 32'd0);
        chk("rst_busy32", 32'(busy32), 32'd0);
        chk("rst_y32", 32'(y32), 32'd0);
        start8 = 1'b0; start32 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        launch(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5);    complete(1'b0, "sq0", 0);
        launch(1'b0, 32'd200, 1'b0, 32'd14, 32'd4, 5); complete(1'b0, "sq200", 0);
        launch(1'b0, 32'd255, 1'b0, 32'd15, 32'd30, 5); complete(1'b0, "sq255", 0);
        launch(1'b0, 32'd1, 1'b0, 32'd1, 32'd0, 5);    complete(1'b0, "sq1", 0);
        launch(1'b0, 32'd27, 1'b1, 32'd3, 32'd0, 4);   complete(1'b0, "cb27", 0);
        launch(1'b0, 32'd64, 1'b1, 32'd4, 32'd0, 4);   complete(1'b0, "cb64", 0);
        launch(1'b0, 32'd255, 1'b1, 32'd6, 32'd39, 4); complete(1'b0, "cb255", 0);
        chk("cb255_next_done", 32'(done8), 32'd1);

        // Start ignored while busy; operand change mid-CALC has no effect.
        launch(1'b0, 32'd255, 1'b1, 32'd6, 32'd39, 4);
        @(posedge clk); #1;
        a8 = 8'd9; mode8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        complete(1'b0, "cb_ign", 2);
        launch(1'b0, 32'd9, 1'b0, 32'd3, 32'd0, 5);    complete(1'b0, "b2b_sq9", 0);

        // Reset mid-CALC abandons the computation.
        @(posedge clk); #1;
        a8 = 8'd255; mode8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_y", 32'(y8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
`ifdef FUNC_ROOT_REM_EN
        chk("midrst_rem", 32'(rem8), 32'd0);
`endif
        last_y8 = 32'd0;
        last_y32 = 32'd0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(busy8 | done8), 32'd0);
        launch(1'b0, 32'd16, 1'b0, 32'd4, 32'd0, 5);   complete(1'b0, "sq16", 0);

        launch(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd65535, 32'd131070, 17); complete(1'b1, "sq32max", 0);
        launch(1'b1, 32'hFFFF_FFFF, 1'b1, 32'd1625, 32'd3951670, 12); complete(1'b1, "cb32max", 0);
        launch(1'b1, 32'd1000000, 1'b1, 32'd100, 32'd0, 12);           complete(1'b1, "cb32_1e6", 0);
        launch(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 17);                   complete(1'b1, "sq32_0", 0);

        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt), 32'(done_exp));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
